// File: rtl/fsm_detector.sv
// Serial pattern detector for the bit sequence 1101.
// Accepted bits walk a five-state FSM; completing the pattern raises a
// one-cycle registered match pulse and bumps a saturating match counter.
//
// Input handshake: in_valid qualifies in_bit and there is no backpressure.
// A bit is consumed on every rising edge where in_valid is high and clear is
// low; with in_valid low the bit is ignored and state/count hold.
//
// Priority on each edge: rst_n > clear > in_valid.
// overlap_en only affects the transition out of S4: when it is high the
// trailing "1" of a found pattern is reused as the start of the next one.
module fsm_detector #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               overlap_en,
  output logic [2:0]         state,
  output logic               match,
  output logic [COUNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // no prefix seen
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "11"
    S3 = 3'd3,  // "110"
    S4 = 3'd4   // "1101" found
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               match_q;
  logic               match_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Next-state, next-match and next-count decode; defaults hold state/count
  // and drop the match pulse.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    count_d = count_q;
    if (clear) begin
      state_d = S0;
      count_d = '0;
    end else if (state_q > S4) begin
      // Codes 5-7 are unreachable in normal operation; recover to S0.
      state_d = S0;
    end else if (in_valid) begin
      case (state_q)
        S0: state_d = in_bit ? S1 : S0;
        S1: state_d = in_bit ? S2 : S0;
        S2: state_d = in_bit ? S2 : S3;
        S3: begin
          if (in_bit) begin
            state_d = S4;
            match_d = 1'b1;
          end else begin
            state_d = S0;
          end
        end
        S4: begin
          if (in_bit) state_d = overlap_en ? S2 : S1;
          else        state_d = S0;
        end
        default: state_d = S0;
      endcase
      // Count moves on the same edge that raises match; stick at all-ones.
      if (match_d && (count_q != '1)) count_d = count_q + COUNT_W'(1);
    end
  end

  // State, match and count registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign state = state_q;
  assign match = match_q;
  assign count = count_q;

endmodule

// File: tb/tb_fsm_detector.sv
// Testbench for fsm_detector: two instances (COUNT_W=8 and COUNT_W=2) share
// the same stimulus; a suffix-matching reference model predicts state, match
// and both counters after every edge.
module tb_fsm_detector;

  localparam int W = 14;  // {state[2:0], match, count8[7:0], count2[1:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       overlap_en = 1'b0;
  logic [2:0] state, state2;
  logic       match, match2;
  logic [7:0] count;
  logic [1:0] count2;

  fsm_detector #(.COUNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_bit(in_bit), .overlap_en(overlap_en),
    .state(state), .match(match), .count(count)
  );

  fsm_detector #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_bit(in_bit), .overlap_en(overlap_en),
    .state(state2), .match(match2), .count(count2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the last few accepted bits since the most recent restart point;
  // the FSM state is the length of the longest suffix that is a prefix of
  // 1101. After a match the next accepted bit either keeps the history
  // (overlap) or starts a fresh one.
  int pat[4] = '{1, 1, 0, 1};
  int hist[$];
  bit m_pend;
  bit m_match;
  int m_cnt8, m_cnt2;

  function automatic int suffix_len();
    for (int k = 4; k >= 1; k--) begin
      if (hist.size() >= k) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (hist[hist.size() - k + i] != pat[i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_pend = 1'b0;
    m_match = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endfunction

  function automatic void model_step(input bit v, input bit b, input bit o, input bit c);
    if (c) begin
      model_reset();
    end else if (v) begin
      if (m_pend && !o) hist.delete();
      m_pend = 1'b0;
      hist.push_back(int'(b));
      if (hist.size() > 4) void'(hist.pop_front());
      m_match = (suffix_len() == 4);
      if (m_match) begin
        m_pend = 1'b1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else begin
      m_match = 1'b0;
    end
    exp_q.push_back({3'(suffix_len()), m_match, 8'(m_cnt8), 2'(m_cnt2)});
  endfunction

  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'(1), 32'(0));
      return;
    end
    e = exp_q.pop_front();
    check("state",  32'(state),  32'(e[13:11]));
    check("match",  32'(match),  32'(e[10]));
    check("count",  32'(count),  32'(e[9:2]));
    check("state2", 32'(state2), 32'(e[13:11]));
    check("match2", 32'(match2), 32'(e[10]));
    check("count2", 32'(count2), 32'(e[1:0]));
  endtask

  // ---------------- drivers ----------------
  // Called just after a rising edge; applies inputs, waits one edge, checks.
  task automatic step(input bit v, input bit b, input bit o, input bit c);
    in_valid = v;
    in_bit = b;
    overlap_en = o;
    clear = c;
    @(posedge clk);
    model_step(v, b, o, c);
    #1;
    compare_outputs();
  endtask

  // Sends n bits MSB-first from bits, optionally with random idle gaps.
  task automatic send(input logic [15:0] bits, input int n, input bit o, input bit gaps);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) step(1'b0, 1'($urandom_range(0, 1)), o, 1'b0);
      end
      step(1'b1, v[i], o, 1'b0);
    end
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    #12;
    check("rst_state", 32'(state), 32'(0));
    check("rst_match", 32'(match), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic 1101 stream.
    send(16'b1101, 4, 1'b0, 1'b0);
    check("basic_cnt", 32'(count), 32'(1));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("basic_pulse_end", 32'(match), 32'(0));

    // Overlapping 1101101 -> two matches, ends in S4.
    do_clear();
    send(16'b1101101, 7, 1'b1, 1'b0);
    check("ovl_cnt", 32'(count), 32'(2));
    check("ovl_state", 32'(state), 32'(4));

    // Non-overlapping 1101101 -> one match, ends in S1.
    do_clear();
    send(16'b1101101, 7, 1'b0, 1'b0);
    check("novl_cnt", 32'(count), 32'(1));
    check("novl_state", 32'(state), 32'(1));

    // 1101 with idle gaps carrying random in_bit.
    do_clear();
    send(16'b1101, 4, 1'b0, 1'b1);
    check("gap_cnt", 32'(count), 32'(1));

    // Edge cases.
    do_clear();
    send(16'b111101, 6, 1'b0, 1'b0);
    check("s2_loop_cnt", 32'(count), 32'(1));
    do_clear();
    send(16'b11001101, 8, 1'b1, 1'b0);
    check("1100_1101_cnt", 32'(count), 32'(1));

    // Five matches: the 2-bit counter saturates at 3.
    do_clear();
    for (int i = 0; i < 5; i++) send(16'b1101, 4, 1'b0, 1'b0);
    check("sat2_cnt", 32'(count2), 32'(3));
    check("sat8_cnt", 32'(count), 32'(5));

    // Clear coinciding with a completing bit.
    send(16'b110, 3, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_match", 32'(match), 32'(0));
    check("clr_count", 32'(count), 32'(0));

    // Asynchronous reset mid-cycle while in S3 with a non-zero count.
    send(16'b1101110, 7, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'(0));
    check("arst_match", 32'(match), 32'(0));
    check("arst_count", 32'(count), 32'(0));
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized stream with occasional clears and overlap changes.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    // 8-bit saturation: 260 overlapped matches.
    do_clear();
    send(16'b1, 1, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) send(16'b101, 3, 1'b1, 1'b0);
    check("sat8_full", 32'(count), 32'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_detector.md
Name: fsm_detector

Overview:
- Synchronous Mealy/Moore hybrid serial pattern detector; finds the bit pattern 1101 in a qualified serial bit stream.
- Emits a one-cycle registered match pulse and keeps a saturating match counter.
- Generic control-path building block; sits between a serial input source and downstream event logic.

Parameters:
- COUNT_W, 8, width of the match counter; the counter saturates at 2^COUNT_W-1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous clear of state, match and count.
- in_valid, input, 1, qualifies in_bit; the bit is consumed only when high.
- in_bit, input, 1, serial data bit.
- overlap_en, input, 1, 1 = overlapping detection, 0 = non-overlapping.
- state, output, 3, current FSM state encoding.
- match, output, 1, registered one-cycle pulse per detected pattern.
- count, output, COUNT_W, saturating number of matches.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, asynchronous, at any time): state=S0 (0), match=0, count=0. Reset mid-pattern discards partial progress.
- State encoding (3 bits):
  - S0=0: no prefix
  - S1=1: "1"
  - S2=2: "11"
  - S3=3: "110"
  - S4=4: "1101" found
  - Codes 5-7 are illegal and go to S0 on the next clock.
- Priority per rising edge: rst_n > clear > in_valid. With clear=1, the next state is S0, match=0 and count=0, regardless of in_valid.
- When in_valid=0 (and no clear): state and count hold, and match is driven 0.
- Transitions when in_valid=1 (bit b):
  - S0: b=1 -> S1; b=0 -> S0.
  - S1: 1 -> S2; 0 -> S0.
  - S2: 1 -> S2; 0 -> S3.
  - S3: 1 -> S4 (completes pattern); 0 -> S0.
  - S4 with overlap_en=1: 1 -> S2; 0 -> S0.
  - S4 with overlap_en=0: 1 -> S1; 0 -> S0.
- overlap_en is sampled on each accepted bit and may change at any time; it affects only transitions out of S4.
- match:
  - Registered. It is 1 in the cycle following the edge that accepts a completing bit (state S3, in_valid=1, in_bit=1).
  - It is 0 in all other cycles.
  - Latency is one clock from the completing bit to the match pulse, which coincides with state=S4.
  - Back-to-back accepted completions cannot occur, because at least 3 bits separate matches.
- count: increments by 1 on the same edge that sets match. It holds at all-ones once it reaches 2^COUNT_W-1 (no wrap).
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then stream 1,1,0,1 with in_valid=1 every cycle: state goes 1,2,3,4; match=1 for exactly one cycle after the 4th bit; count=1.
- overlap_en=1, stream 1101101: two match pulses, after bits 4 and 7; count=2; final state=4.
- overlap_en=0, same stream 1101101: one match pulse after bit 4; final state=1; count=1.
- Stream 1,1,0,1 with in_valid=0 cycles inserted between bits (in_bit toggling randomly during the gaps): state holds during gaps, exactly one match is produced, and match=0 during gaps.
- Edge cases:
  - Stream 111101: one match after the 6th bit, since S2 self-loops on 1.
  - Stream 1100 1101: one match only.
- Saturation, reset and clear:
  - With COUNT_W=2, produce 5 matches: count goes 1,2,3,3,3.
  - Assert rst_n=0 asynchronously mid-clock while in S3: state, match and count all read 0 immediately.
  - Assert clear=1 together with a completing bit: no match, and count=0.
